// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out shifter with EN-gated advance.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    input  logic         load_v,
    output logic         load_r,
    input  logic         dir,
    input  logic         en,
    output logic         so,
    output logic         so_v,
    output logic         done
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
`ifdef PISO_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    localparam state_t AFTER_SHIFT = PARITY ? PAR : IDLE;

    state_t state, state_nxt;
    logic [W-1:0] sreg;
    logic [CW-1:0] cnt;
    logic order, par, accept, step, last;
    logic so_nxt, so_v_nxt, done_nxt;

    assign load_r = state == IDLE;
    assign accept = load_v && load_r;
    assign step   = en && state == SHIFT;
    assign last   = cnt == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = load_v ? SHIFT : IDLE;
            SHIFT:   state_nxt = (en && last) ? AFTER_SHIFT : SHIFT;
            PAR:     state_nxt = en ? IDLE : PAR;
            default: state_nxt = IDLE;
        endcase
    end

    // SO is precomputed for the next cycle so it leaves a flop, never the mux.
    always_comb begin
        so_v_nxt = state_nxt != IDLE;
        done_nxt = state != IDLE && state_nxt == IDLE;
        so_nxt   = state_nxt == IDLE ? 1'b0 :
                   accept            ? (dir ? d[0] : d[W-1]) :
                   state_nxt == PAR  ? par :
                   !step             ? so :
                   (order ? sreg[1] : sreg[W-2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            cnt   <= '0;
            order <= 1'b0;
            par   <= 1'b0;
            so    <= 1'b0;
            so_v  <= 1'b0;
            done  <= 1'b0;
        end else begin
            so   <= so_nxt;
            so_v <= so_v_nxt;
            done <= done_nxt;
            if (accept) begin
                sreg  <= d;
                order <= dir;
                par   <= ^d;
                cnt   <= '0;
            end else if (step) begin
                sreg <= order ? sreg >> 1 : sreg << 1;
                if (!last) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed scenario bench for piso_serializer.
module tb_piso_serializer;
    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 0, rst_n = 1, load_v = 0, dir = 0, en = 0;
    logic [W-1:0] d = '0;
    logic load_r, so, so_v, done;
    int compared = 0, mismatched = 0;

    piso_serializer #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .load_v(load_v), .load_r(load_r),
        .dir(dir), .en(en), .so(so), .so_v(so_v), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [W-1:0] w, input logic dr);
        d = w;
        dir = dr;
        load_v = 1;
        en = 1;
        tick;
        load_v = 0;
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        #2;
        compared++;
        if (so !== 0 || so_v !== 0 || done !== 0 || load_r !== 1) begin
            mismatched++;
            $display("FAIL reset: so=%b so_v=%b done=%b load_r=%b, expected 0 0 0 1", so, so_v, done, load_r);
        end
        tick;
        rst_n = 1;
        tick;
        compared++;
        if (so_v !== 0 || done !== 0 || load_r !== 1) begin
            mismatched++;
            $display("FAIL reset_idle: so_v=%b done=%b load_r=%b, expected 0 0 1", so_v, done, load_r);
        end
    endtask

    task automatic test_msb;
        logic [8:0] seq = 9'b1010_0101_0;
        start(8'hA5, 0);
        for (int i = 0; i < W + P; i++) begin
            compared++;
            if (so !== seq[8-i] || so_v !== 1 || load_r !== 0 || done !== 0) begin
                mismatched++;
                $display("FAIL msb bit%0d: so=%b so_v=%b load_r=%b done=%b, expected so=%b 1 0 0", i, so, so_v, load_r, done, seq[8-i]);
            end
            tick;
        end
        compared++;
        if (done !== 1 || so_v !== 0 || so !== 0 || load_r !== 1) begin
            mismatched++;
            $display("FAIL msb_done: done=%b so_v=%b so=%b load_r=%b, expected 1 0 0 1", done, so_v, so, load_r);
        end
        tick;
        compared++;
        if (done !== 0) begin
            mismatched++;
            $display("FAIL msb_done_pulse: done=%b, expected 0", done);
        end
    endtask

    task automatic test_lsb;
        logic [8:0] seq = 9'b1110_0000_1;
        start(8'h07, 1);
        for (int i = 0; i < W + P; i++) begin
            compared++;
            if (so !== seq[8-i] || so_v !== 1) begin
                mismatched++;
                $display("FAIL lsb bit%0d: so=%b so_v=%b, expected so=%b so_v=1", i, so, so_v, seq[8-i]);
            end
            tick;
        end
        compared++;
        if (done !== 1 || so_v !== 0) begin
            mismatched++;
            $display("FAIL lsb_done: done=%b so_v=%b, expected 1 0", done, so_v);
        end
        tick;
    endtask

    task automatic test_stall;
        logic [8:0] seq = 9'b1100_0011_0;
        int cyc = 0;
        start(8'hC3, 0);
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (so !== seq[8-i]) begin
                mismatched++;
                $display("FAIL stall_pre bit%0d: so=%b, expected %b", i, so, seq[8-i]);
            end
            tick;
            cyc++;
        end
        en = 0;
        for (int k = 0; k < 5; k++) begin
            compared++;
            if (so !== 0 || so_v !== 1 || done !== 0) begin
                mismatched++;
                $display("FAIL stall_hold%0d: so=%b so_v=%b done=%b, expected 0 1 0", k, so, so_v, done);
            end
            tick;
            cyc++;
        end
        en = 1;
        for (int i = 2; i < W + P; i++) begin
            compared++;
            if (so !== seq[8-i] || so_v !== 1) begin
                mismatched++;
                $display("FAIL stall bit%0d: so=%b so_v=%b, expected so=%b so_v=1", i, so, so_v, seq[8-i]);
            end
            tick;
            cyc++;
        end
        compared++;
        if (done !== 1 || cyc !== W + P + 5) begin
            mismatched++;
            $display("FAIL stall_done: done=%b after %0d cycles, expected 1 after %0d", done, cyc, W + P + 5);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [8:0] s1 = 9'b1000_0001_0;
        logic [8:0] s2 = 9'b0011_1100_0;
        d = 8'h81;
        dir = 0;
        load_v = 1;
        en = 1;
        tick;
        d = 8'h3C;
        for (int i = 0; i < W + P; i++) begin
            compared++;
            if (so !== s1[8-i] || so_v !== 1 || load_r !== 0) begin
                mismatched++;
                $display("FAIL b2b_w1 bit%0d: so=%b so_v=%b load_r=%b, expected so=%b 1 0", i, so, so_v, load_r, s1[8-i]);
            end
            tick;
        end
        compared++;
        if (done !== 1 || load_r !== 1 || so_v !== 0) begin
            mismatched++;
            $display("FAIL b2b_done1: done=%b load_r=%b so_v=%b, expected 1 1 0", done, load_r, so_v);
        end
        tick;
        load_v = 0;
        for (int i = 0; i < W + P; i++) begin
            compared++;
            if (so !== s2[8-i] || so_v !== 1 || done !== 0) begin
                mismatched++;
                $display("FAIL b2b_w2 bit%0d: so=%b so_v=%b done=%b, expected so=%b 1 0", i, so, so_v, done, s2[8-i]);
            end
            tick;
        end
        compared++;
        if (done !== 1) begin
            mismatched++;
            $display("FAIL b2b_done2: done=%b, expected 1", done);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [8:0] seq = 9'b0000_0001_1;
        start(8'hFF, 0);
        tick;
        tick;
        tick;
        #2 rst_n = 0;
        #1;
        compared++;
        if (so !== 0 || so_v !== 0 || load_r !== 1 || done !== 0) begin
            mismatched++;
            $display("FAIL rst_mid: so=%b so_v=%b load_r=%b done=%b, expected 0 0 1 0", so, so_v, load_r, done);
        end
        tick;
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (done !== 0 || so_v !== 0) begin
                mismatched++;
                $display("FAIL rst_mid_nodone%0d: done=%b so_v=%b, expected 0 0", k, done, so_v);
            end
            if (k < 2) tick;
        end
        start(8'h01, 0);
        for (int i = 0; i < W + P; i++) begin
            compared++;
            if (so !== seq[8-i] || so_v !== 1) begin
                mismatched++;
                $display("FAIL rst_reload bit%0d: so=%b so_v=%b, expected so=%b so_v=1", i, so, so_v, seq[8-i]);
            end
            tick;
        end
        compared++;
        if (done !== 1) begin
            mismatched++;
            $display("FAIL rst_reload_done: done=%b, expected 1", done);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_msb;
        test_lsb;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parameterised parallel-in/serial-out shift stage that accepts a W-bit word on a valid/ready handshake and emits it one bit per enabled cycle. It sits directly upstream of the NAND-built 2:1 mux stage: SO drives a mux data input and SO_V drives the mux select, so the mux passes serialized data when SO_V=1 and its alternate input otherwise. All outputs are registered, except LOAD_R, which is decoded from state.

## Interface
- W, default 8: data word width, ≥2.
- CLK  input  1  rising-edge clock; single clock domain.
- RST_N  input  1  asynchronous, active-low reset.
- D  input  W  parallel word; sampled only on an accepted load.
- LOAD_V  input  1  D is valid and requests a load.
- LOAD_R  output  1  block can accept a load; 1 exactly when the FSM is in IDLE.
- DIR  input  1  bit order, sampled with D: 0 = MSB first, 1 = LSB first.
- EN  input  1  advance enable; while low, SO/SO_V hold.
- SO  output  1  current serial bit.
- SO_V  output  1  SO is valid.
- DONE  output  1  one-cycle pulse after the final bit is consumed.

## Operation
- States:
  - IDLE: LOAD_R=1, SO_V=0.
  - SHIFT: SO_V=1, data bits.
  - PAR: SO_V=1, parity bit; exists only with the configuration macro.
- Load:
  - Accepted on a rising CLK edge with LOAD_V=1 and LOAD_R=1.
  - On acceptance: shift register ← D, order ← DIR, bit counter ← 0, state → SHIFT.
  - LOAD_V in SHIFT/PAR is ignored; no data is lost or queued.
- SHIFT:
  - SO = D[W-1-cnt] if order=0, otherwise D[cnt].
  - A bit is consumed on an edge with EN=1; cnt increments.
  - Consuming the bit with cnt=W-1 moves to IDLE, or to PAR if configured.
- Counter: width $clog2(W); it never wraps inside a word and is cleared on every accepted load.
- DONE: registered, set for exactly one cycle in the first IDLE cycle after the last bit (data or parity) is consumed.
- When DONE=1 the block is already in IDLE, so LOAD_R=1 and a load in that cycle is accepted. Minimum gap between words is therefore one cycle.
- Reset (RST_N=0, asynchronous, at any time including mid-word):
  - State → IDLE, SO=0, SO_V=0, DONE=0, cnt=0, shift register=0.
  - LOAD_R=1 while in reset.
  - The partial word is discarded and no DONE is emitted.
- In IDLE: SO=0.

## Timing
- Load latency: first bit on SO with SO_V=1 in the cycle after the accepting edge.
- With EN held high, a word occupies W cycles (W+1 with parity) of SO_V=1, then DONE follows in the next cycle.
- EN low stretches any bit indefinitely; SO is stable for the whole period SO_V=1 and EN=0.
- Reset release: the first load can be accepted on the first CLK edge after RST_N rises.

## Configuration
- PISO_PARITY_EN:
  - Defined: after the W data bits, state PAR emits one even-parity bit, SO = ^word, consumed under the same EN rule. The word is W+1 SO_V cycles.
  - Undefined: no PAR state; the word is W cycles and the FSM goes SHIFT→IDLE directly.
  - LOAD_R and DONE semantics are identical in both builds.

## Test plan
- Reset mid-word: load 8'hFF, consume 3 bits, pulse RST_N low → immediately SO=0, SO_V=0, LOAD_R=1, DONE never asserts; the next load of 8'h01 serializes correctly.
- Basic MSB-first: load 8'hA5, DIR=0, EN=1 → SO sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then DONE=1 for one cycle. With parity, a ninth bit 0 precedes DONE.
- LSB-first with parity: load 8'h07, DIR=1 → SO 1,1,1,0,0,0,0,0, then parity bit 1, then DONE.
- Stall: load 8'hC3, hold EN=0 for 5 cycles at bit 2 → SO holds 0 with SO_V=1; completion is delayed by exactly 5 cycles.
- Back-to-back/ignored load: hold LOAD_V=1 with D=8'h3C throughout word 8'h81 → the second word is accepted only in the DONE cycle; the first SO of word 2 appears one cycle after DONE.
